// File: rtl/move_sequencer_pkg.sv
// Shared types and board constants for the player move sequencer and the game-core integration.
// Pure declarations: no latency and no backpressure.
package move_sequencer_pkg;

    localparam int NUM_CELLS      = 9;
    localparam int CELL_W         = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int WD_W           = 5;

    localparam logic [NUM_CELLS-1:0] BOARD_ALL = {NUM_CELLS{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        PLACE,
        READY,
        SEND,
        WAIT_ALU,
        CHECK,
        WIN,
        LOSE
    } seq_state_t;

    // Every cell is either cleared or mined, and no mine has been cleared.
    function automatic logic board_won(input logic [NUM_CELLS-1:0] mask,
                                       input logic [NUM_CELLS-1:0] mines);
        return ((mask | mines) == BOARD_ALL) && ((mask & mines) == '0);
    endfunction

endpackage

// File: rtl/move_watchdog.sv
// Watchdog counter for waits on the game core; clear wins over enable.
// expired_o decodes the counter register in the cycle it reaches TIMEOUT_CYCLES-1; no backpressure.
module move_watchdog
    import move_sequencer_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [WD_W-1:0] count_q;
    logic [WD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == WD_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/move_sequencer.sv
// Turns player requests into place/move handshakes for the game core and tracks game status.
// Move strobe one cycle after acceptance; requests are only taken while out_cell_ready is high.
module move_sequencer
    import move_sequencer_pkg::*;
(
    input  logic                 in_clka,
    input  logic                 in_restart,
    input  logic                 in_start_req,
    input  logic                 in_cell_valid,
    input  logic [CELL_W-1:0]    in_cell_sel,
    output logic                 out_cell_ready,
    output logic                 out_place,
    output logic                 out_data_in,
    output logic [CELL_W-1:0]    out_data,
    input  logic                 in_place_done,
    input  logic                 in_alu_done,
    input  logic                 in_gameover,
    input  logic [NUM_CELLS-1:0] in_mines,
    input  logic [NUM_CELLS-1:0] in_temp_cleared,
    output logic                 out_reject,
    output logic [CELL_W-1:0]    out_moves,
    output logic                 out_win,
    output logic                 out_lose,
    output logic                 out_error
);

    seq_state_t           state_q, state_d;
    logic [NUM_CELLS-1:0] mask_q, mask_d;
    logic [NUM_CELLS-1:0] cleared_q, cleared_d;
    logic [NUM_CELLS-1:0] mines_q, mines_d;
    logic                 gameover_q, gameover_d;
    logic [CELL_W-1:0]    moves_q, moves_d;
    logic [CELL_W-1:0]    data_q, data_d;
    logic                 place_q, place_d;
    logic                 ready_q, ready_d;
    logic                 strobe_q, strobe_d;
    logic                 reject_q, reject_d;
    logic                 win_q, win_d;
    logic                 lose_q, lose_d;
    logic                 error_q, error_d;

    logic                 new_game;
    logic                 wd_clr;
    logic                 wd_en;
    logic                 wd_expired;
    logic [NUM_CELLS-1:0] sel_bit;
    logic                 sel_illegal;

    // Out-of-range selects shift the bit off the board, so sel_bit is 0 for them.
    assign sel_bit     = NUM_CELLS'(1) << in_cell_sel;
    assign sel_illegal = (in_cell_sel >= CELL_W'(NUM_CELLS)) || ((mask_q & sel_bit) != '0);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        cleared_d  = cleared_q;
        mines_d    = mines_q;
        gameover_d = gameover_q;
        moves_d    = moves_q;
        data_d     = data_q;
        reject_d   = 1'b0;
        win_d      = win_q;
        lose_d     = lose_q;
        error_d    = error_q;
        new_game   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_start_req) begin
                    state_d  = PLACE;
                    new_game = 1'b1;
                end
            end
            PLACE: begin
                if (in_place_done) begin
                    state_d = READY;
                end else if (wd_expired) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            READY: begin
                if (in_cell_valid) begin
                    if (sel_illegal) begin
                        reject_d = 1'b1;
                    end else begin
                        data_d  = in_cell_sel;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                state_d = WAIT_ALU;
            end
            WAIT_ALU: begin
                if (in_alu_done) begin
                    cleared_d  = in_temp_cleared;
                    mines_d    = in_mines;
                    gameover_d = in_gameover;
                    state_d    = CHECK;
                end else if (wd_expired) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            CHECK: begin
                if (moves_q < CELL_W'(NUM_CELLS)) begin
                    moves_d = moves_q + CELL_W'(1);
                end
                mask_d = cleared_q;
                if (gameover_q) begin
                    state_d = LOSE;
                    lose_d  = 1'b1;
                end else if (board_won(cleared_q, mines_q)) begin
                    state_d = WIN;
                    win_d   = 1'b1;
                end else begin
                    state_d = READY;
                end
            end
            WIN, LOSE: begin
                state_d = state_q;
            end
            default: state_d = IDLE;
        endcase

        // A new-game request aborts mid-game work, including a same-cycle move or done strobe.
        if (in_start_req && (state_q != IDLE) && (state_q != PLACE)) begin
            state_d  = PLACE;
            new_game = 1'b1;
            reject_d = 1'b0;
            data_d   = data_q;
        end

        if (new_game) begin
            mask_d  = '0;
            moves_d = '0;
            win_d   = 1'b0;
            lose_d  = 1'b0;
            error_d = 1'b0;
        end

        place_d  = (state_d == PLACE);
        ready_d  = (state_d == READY);
        strobe_d = (state_d == SEND);
    end

    assign wd_en  = (state_q == PLACE) || (state_q == WAIT_ALU);
    assign wd_clr = ((state_d == PLACE) && (state_q != PLACE)) ||
                    ((state_d == WAIT_ALU) && (state_q != WAIT_ALU));

    move_watchdog u_watchdog (
        .clk_i     (in_clka),
        .rst_i     (in_restart),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_ff @(posedge in_clka or posedge in_restart) begin
        if (in_restart) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            cleared_q  <= '0;
            mines_q    <= '0;
            gameover_q <= 1'b0;
            moves_q    <= '0;
            data_q     <= '0;
            place_q    <= 1'b0;
            ready_q    <= 1'b0;
            strobe_q   <= 1'b0;
            reject_q   <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            cleared_q  <= cleared_d;
            mines_q    <= mines_d;
            gameover_q <= gameover_d;
            moves_q    <= moves_d;
            data_q     <= data_d;
            place_q    <= place_d;
            ready_q    <= ready_d;
            strobe_q   <= strobe_d;
            reject_q   <= reject_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            error_q    <= error_d;
        end
    end

    assign out_cell_ready = ready_q;
    assign out_place      = place_q;
    assign out_data_in    = strobe_q;
    assign out_data       = data_q;
    assign out_reject     = reject_q;
    assign out_moves      = moves_q;
    assign out_win        = win_q;
    assign out_lose       = lose_q;
    assign out_error      = error_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: each task drives one scenario and checks hand-computed values.
module tb_move_sequencer;
    import move_sequencer_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start_req = 1'b0;
    logic                 cell_valid = 1'b0;
    logic [CELL_W-1:0]    cell_sel = '0;
    logic                 cell_ready;
    logic                 place;
    logic                 data_in;
    logic [CELL_W-1:0]    data;
    logic                 place_done = 1'b0;
    logic                 alu_done = 1'b0;
    logic                 gameover = 1'b0;
    logic [NUM_CELLS-1:0] mines = '0;
    logic [NUM_CELLS-1:0] temp_cleared = '0;
    logic                 reject;
    logic [CELL_W-1:0]    moves;
    logic                 win;
    logic                 lose;
    logic                 error;

    int vectors = 0;
    int miscompares = 0;

    move_sequencer dut (
        .in_clka         (clk),
        .in_restart      (rst),
        .in_start_req    (start_req),
        .in_cell_valid   (cell_valid),
        .in_cell_sel     (cell_sel),
        .out_cell_ready  (cell_ready),
        .out_place       (place),
        .out_data_in     (data_in),
        .out_data        (data),
        .in_place_done   (place_done),
        .in_alu_done     (alu_done),
        .in_gameover     (gameover),
        .in_mines        (mines),
        .in_temp_cleared (temp_cleared),
        .out_reject      (reject),
        .out_moves       (moves),
        .out_win         (win),
        .out_lose        (lose),
        .out_error       (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_game();
        start_req = 1'b1;
        tick();
        start_req  = 1'b0;
        place_done = 1'b1;
        tick();
        place_done = 1'b0;
    endtask

    task automatic play_move(input logic [CELL_W-1:0] sel, input logic [NUM_CELLS-1:0] clr,
                             input logic [NUM_CELLS-1:0] mn, input logic go, input int dly);
        cell_valid = 1'b1;
        cell_sel   = sel;
        tick();
        cell_valid = 1'b0;
        tick();
        repeat (dly) tick();
        alu_done     = 1'b1;
        temp_cleared = clr;
        mines        = mn;
        gameover     = go;
        tick();
        alu_done = 1'b0;
        gameover = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        vectors++; if ({cell_ready, place, data_in, reject, win, lose, error} !== 7'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 0000000", {cell_ready, place, data_in, reject, win, lose, error}); end
        vectors++; if (moves !== 4'd0 || data !== 4'd0) begin miscompares++; $display("FAIL reset_counts: moves %0d data %0d want 0 0", moves, data); end
        vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); end
        rst = 1'b0;
        tick();
        vectors++; if (place !== 1'b0 || cell_ready !== 1'b0) begin miscompares++; $display("FAIL idle_hold: place %b ready %b want 0 0", place, cell_ready); end
    endtask

    task automatic test_start();
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        vectors++; if (place !== 1'b1) begin miscompares++; $display("FAIL start_place: got %b want 1", place); end
        repeat (2) tick();
        vectors++; if (place !== 1'b1 || cell_ready !== 1'b0) begin miscompares++; $display("FAIL place_wait: place %b ready %b want 1 0", place, cell_ready); end
        place_done = 1'b1;
        tick();
        place_done = 1'b0;
        vectors++; if (cell_ready !== 1'b1 || place !== 1'b0) begin miscompares++; $display("FAIL place_done: ready %b place %b want 1 0", cell_ready, place); end
    endtask

    task automatic test_move();
        cell_valid = 1'b1;
        cell_sel   = 4'd2;
        tick();
        cell_valid = 1'b0;
        vectors++; if (data_in !== 1'b1 || data !== 4'd2 || cell_ready !== 1'b0) begin miscompares++; $display("FAIL move_strobe: strobe %b data %0d ready %b want 1 2 0", data_in, data, cell_ready); end
        tick();
        vectors++; if (data_in !== 1'b0 || data !== 4'd2) begin miscompares++; $display("FAIL move_one_cycle: strobe %b data %0d want 0 2", data_in, data); end
        repeat (3) tick();
        alu_done     = 1'b1;
        temp_cleared = 9'h004;
        mines        = 9'h101;
        tick();
        alu_done = 1'b0;
        vectors++; if (moves !== 4'd0 || cell_ready !== 1'b0) begin miscompares++; $display("FAIL move_check_cycle: moves %0d ready %b want 0 0", moves, cell_ready); end
        tick();
        vectors++; if (moves !== 4'd1 || cell_ready !== 1'b1 || win !== 1'b0 || lose !== 1'b0) begin miscompares++; $display("FAIL move_done: moves %0d ready %b win %b lose %b want 1 1 0 0", moves, cell_ready, win, lose); end
    endtask

    task automatic test_reject();
        logic [CELL_W-1:0] sels [2];
        sels[0] = 4'd9;
        sels[1] = 4'd2;
        for (int i = 0; i < 2; i++) begin
            cell_valid = 1'b1;
            cell_sel   = sels[i];
            tick();
            cell_valid = 1'b0;
            vectors++; if (reject !== 1'b1 || data_in !== 1'b0 || cell_ready !== 1'b1) begin miscompares++; $display("FAIL reject_pulse sel %0d: reject %b strobe %b ready %b want 1 0 1", sels[i], reject, data_in, cell_ready); end
            tick();
            vectors++; if (reject !== 1'b0 || data_in !== 1'b0 || moves !== 4'd1) begin miscompares++; $display("FAIL reject_after sel %0d: reject %b strobe %b moves %0d want 0 0 1", sels[i], reject, data_in, moves); end
        end
    endtask

    task automatic test_stray_done();
        alu_done     = 1'b1;
        place_done   = 1'b1;
        gameover     = 1'b1;
        temp_cleared = 9'h1FF;
        mines        = 9'h000;
        tick();
        alu_done   = 1'b0;
        place_done = 1'b0;
        gameover   = 1'b0;
        tick();
        vectors++; if (lose !== 1'b0 || win !== 1'b0 || moves !== 4'd1 || cell_ready !== 1'b1) begin miscompares++; $display("FAIL stray_done: lose %b win %b moves %0d ready %b want 0 0 1 1", lose, win, moves, cell_ready); end
    endtask

    task automatic test_win();
        play_move(4'd1, 9'h0FE, 9'h101, 1'b0, 2);
        vectors++; if (win !== 1'b1 || lose !== 1'b0 || moves !== 4'd2 || cell_ready !== 1'b0) begin miscompares++; $display("FAIL win: win %b lose %b moves %0d ready %b want 1 0 2 0", win, lose, moves, cell_ready); end
        cell_valid = 1'b1;
        cell_sel   = 4'd3;
        tick();
        cell_valid = 1'b0;
        tick();
        vectors++; if (win !== 1'b1 || data_in !== 1'b0 || moves !== 4'd2) begin miscompares++; $display("FAIL win_hold: win %b strobe %b moves %0d want 1 0 2", win, data_in, moves); end
    endtask

    task automatic test_lose();
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        vectors++; if (place !== 1'b1 || win !== 1'b0 || moves !== 4'd0) begin miscompares++; $display("FAIL restart_from_win: place %b win %b moves %0d want 1 0 0", place, win, moves); end
        place_done = 1'b1;
        tick();
        place_done = 1'b0;
        play_move(4'd0, 9'h001, 9'h001, 1'b1, 0);
        vectors++; if (lose !== 1'b1 || win !== 1'b0 || moves !== 4'd1 || cell_ready !== 1'b0) begin miscompares++; $display("FAIL lose: lose %b win %b moves %0d ready %b want 1 0 1 0", lose, win, moves, cell_ready); end
        repeat (3) tick();
        vectors++; if (lose !== 1'b1) begin miscompares++; $display("FAIL lose_sticky: got %b want 1", lose); end
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        vectors++; if (place !== 1'b1 || lose !== 1'b0 || moves !== 4'd0) begin miscompares++; $display("FAIL restart_from_lose: place %b lose %b moves %0d want 1 0 0", place, lose, moves); end
        place_done = 1'b1;
        tick();
        place_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            play_move(4'd0, 9'h000, 9'h000, 1'b0, 1);
            vectors++; if (moves !== ((i < 9) ? 4'(i + 1) : 4'd9) || cell_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_move %0d: moves %0d ready %b want %0d 1", i, moves, cell_ready, (i < 9) ? i + 1 : 9); end
        end
    endtask

    task automatic test_abort_place_timeout();
        start_req  = 1'b1;
        cell_valid = 1'b1;
        cell_sel   = 4'd4;
        tick();
        start_req  = 1'b0;
        cell_valid = 1'b0;
        vectors++; if (place !== 1'b1 || data_in !== 1'b0 || cell_ready !== 1'b0 || moves !== 4'd0) begin miscompares++; $display("FAIL abort_priority: place %b strobe %b ready %b moves %0d want 1 0 0 0", place, data_in, cell_ready, moves); end
        repeat (15) tick();
        vectors++; if (place !== 1'b1 || error !== 1'b0) begin miscompares++; $display("FAIL place_wd_early: place %b error %b want 1 0", place, error); end
        tick();
        vectors++; if (error !== 1'b1 || place !== 1'b0 || dut.state_q !== IDLE) begin miscompares++; $display("FAIL place_wd: error %b place %b state %0d want 1 0 %0d", error, place, dut.state_q, IDLE); end
    endtask

    task automatic test_alu_timeout();
        begin_game();
        vectors++; if (error !== 1'b0 || cell_ready !== 1'b1) begin miscompares++; $display("FAIL error_cleared: error %b ready %b want 0 1", error, cell_ready); end
        cell_valid = 1'b1;
        cell_sel   = 4'd5;
        tick();
        cell_valid = 1'b0;
        tick();
        repeat (15) tick();
        vectors++; if (error !== 1'b0 || dut.state_q !== WAIT_ALU) begin miscompares++; $display("FAIL alu_wd_early: error %b state %0d want 0 %0d", error, dut.state_q, WAIT_ALU); end
        tick();
        vectors++; if (error !== 1'b1 || cell_ready !== 1'b0 || dut.state_q !== IDLE) begin miscompares++; $display("FAIL alu_wd: error %b ready %b state %0d want 1 0 %0d", error, cell_ready, dut.state_q, IDLE); end
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tick();
        vectors++; if (moves !== 4'd0 || error !== 1'b1 || dut.state_q !== IDLE) begin miscompares++; $display("FAIL late_done: moves %0d error %b state %0d want 0 1 %0d", moves, error, dut.state_q, IDLE); end
    endtask

    task automatic test_restart_mid();
        begin_game();
        cell_valid = 1'b1;
        cell_sel   = 4'd3;
        tick();
        cell_valid = 1'b0;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++; if ({cell_ready, place, data_in, reject, win, lose, error} !== 7'b0 || data !== 4'd0 || moves !== 4'd0) begin miscompares++; $display("FAIL async_restart: flags %b data %0d moves %0d want 0 0 0", {cell_ready, place, data_in, reject, win, lose, error}, data, moves); end
        vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL async_restart_state: got %0d want %0d", dut.state_q, IDLE); end
        tick();
        rst      = 1'b0;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (data_in !== 1'b0 || place !== 1'b0 || moves !== 4'd0) begin miscompares++; $display("FAIL post_restart %0d: strobe %b place %b moves %0d want 0 0 0", i, data_in, place, moves); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_move();
        test_reject();
        test_stray_done();
        test_win();
        test_lose();
        test_back_to_back();
        test_abort_place_timeout();
        test_alu_timeout();
        test_restart_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
